tlb_ctrl: RTL
=============

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; IDXW = $clog2(TLBNUM).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, TLB instruction request.
REQ-005 SHALL have port cmd_ready, output, 1, request accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_op, input, 2, 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-007 SHALL have ports cmd_vpn2 (input, 19), cmd_asid (input, 8) and cmd_index (input, IDXW), carrying EntryHi and Index operands.
REQ-008 SHALL have ports cmd_lo0 and cmd_lo1, input, 26 each, {pfn[19:0], c[2:0], d, v, g}.
REQ-009 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1), the result handshake.
REQ-010 SHALL have ports resp_found (output, 1) and resp_index (output, IDXW), the TLBP result.
REQ-011 SHALL have ports resp_vpn2 (output, 19), resp_asid (output, 8), resp_lo0 (output, 26) and resp_lo1 (output, 26), the TLBR result; g is replicated into both lo fields.
REQ-012 SHALL have TLB search side ports s_vpn2 (output, 19), s_asid (output, 8), s_found (input, 1) and s_index (input, IDXW).
REQ-013 SHALL have TLB write side ports we (output, 1), w_index (output, IDXW), w_vpn2 (output, 19), w_asid (output, 8) and w_g (output, 1), plus w_pfn0/w_c0/w_d0/w_v0 and w_pfn1/w_c1/w_d1/w_v1 as outputs of widths 20/3/1/1.
REQ-014 SHALL have TLB read side ports r_index (output, IDXW) and r_vpn2/r_asid/r_g/r_pfn0/r_c0/r_d0/r_v0/r_pfn1/r_c1/r_d1/r_v1 (inputs, widths matching the TLB).

Function
REQ-015 SHALL implement the FSM states IDLE, EXEC and RESP; cmd_ready = (state==IDLE).
REQ-016 IDLE->EXEC on accept; operands SHALL be captured into internal registers on that edge.
REQ-017 EXEC SHALL last exactly one cycle and transition to RESP.
REQ-018 RESP SHALL assert resp_valid, and hold it and all resp_* fields stable until resp_ready, then transition to IDLE.
REQ-019 TLBP: s_vpn2/s_asid SHALL be driven from the captured registers during EXEC; s_found/s_index SHALL be sampled into resp_found/resp_index at the end of EXEC. When s_found=0, resp_index SHALL be 0.
REQ-020 TLBR: r_index SHALL equal the captured index during EXEC; r_* SHALL be sampled at the end of EXEC; resp_found SHALL be 0.
REQ-021 TLBWI/TLBWR: we SHALL be 1 for exactly the EXEC cycle and 0 otherwise; w_g = lo0.g & lo1.g; the other w_* fields SHALL come from the captured lo0/lo1/vpn2/asid.
REQ-022 w_index SHALL be the captured index for TLBWI and the random index latched at accept for TLBWR.
REQ-023 Latency SHALL be accept at edge N, resp_valid high from N+2, and next accept no earlier than the edge after resp handshake plus one cycle (IDLE re-entered).
REQ-024 Outside EXEC, s_*/r_index/w_* SHALL hold their last values; we SHALL be 0.
REQ-025 cmd_valid while not IDLE SHALL be ignored; cmd_* SHALL not be sampled.
REQ-026 Responses for write ops SHALL still use the RESP handshake with resp_found=0.

Reset
REQ-027 Reset SHALL force state to IDLE, and drive cmd_ready=1, resp_valid=0, we=0 and all resp_*, s_*, w_* and r_index to 0.
REQ-028 Reset asserted during EXEC SHALL suppress we immediately (asynchronously), so no TLB write occurs.
REQ-029 After reset the random counter SHALL equal TLBNUM-1.

Configuration
REQ-030 The macro TLB_RANDOM_EN SHALL select the TLBWR index source.
REQ-031 With TLB_RANDOM_EN defined, a random counter SHALL decrement every cycle not in reset, wrapping from 0 to TLBNUM-1, and TLBWR SHALL use its value at accept.
REQ-032 With TLB_RANDOM_EN undefined, no counter SHALL exist and TLBWR SHALL behave identically to TLBWI (cmd_index).

Verification
REQ-033 The bench SHALL cover TLBWI index=3, vpn2=0x12345, asid=0x0A, lo0.g=lo1.g=1 -> we=1 for one cycle, w_index=3, w_g=1, then resp_valid with resp_found=0.
REQ-034 The bench SHALL cover TLBP vpn2=0x12345, asid=0x55, with s_found=1/s_index=3 returned -> resp_found=1, resp_index=3, resp_valid at accept+2.
REQ-035 The bench SHALL cover TLBR index=3 -> r_index=3 in EXEC; resp_vpn2=0x12345, resp_asid=0x0A, resp_lo0 returning written pfn/c/d/v with g=1.
REQ-036 The bench SHALL cover resp_ready held 0 for 5 cycles -> resp_* stable, cmd_ready=0, and a new cmd_valid ignored.
REQ-037 The bench SHALL cover TLBWR with TLB_RANDOM_EN, accepted 2 cycles after reset release -> w_index=TLBNUM-3 (13); without the macro -> w_index=cmd_index.
REQ-038 The bench SHALL cover reset asserted mid-EXEC of TLBWI -> we drops the same cycle, entry unchanged, and state returns to IDLE.

Source files
------------

// File: rtl/tlb_ctrl_if.sv
// Purpose: bundles the TLB-instruction command/response handshake and the
//          search/write/read side buses of the TLB array for tlb_ctrl.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on the request, resp_valid/resp_ready on the result.
// Ports/modports:
//   slave  - controller view: accepts cmd_*, returns resp_*, drives s_*/w_*/r_index.
//   master - requester + TLB array view: the mirror image of slave.
interface tlb_ctrl_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  // instruction request
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [18:0]     cmd_vpn2;
  logic [7:0]      cmd_asid;
  logic [IDXW-1:0] cmd_index;
  logic [25:0]     cmd_lo0;
  logic [25:0]     cmd_lo1;

  // instruction result
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_found;
  logic [IDXW-1:0] resp_index;
  logic [18:0]     resp_vpn2;
  logic [7:0]      resp_asid;
  logic [25:0]     resp_lo0;
  logic [25:0]     resp_lo1;

  // TLB search side
  logic [18:0]     s_vpn2;
  logic [7:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;

  // TLB write side
  logic            we;
  logic [IDXW-1:0] w_index;
  logic [18:0]     w_vpn2;
  logic [7:0]      w_asid;
  logic            w_g;
  logic [19:0]     w_pfn0;
  logic [2:0]      w_c0;
  logic            w_d0;
  logic            w_v0;
  logic [19:0]     w_pfn1;
  logic [2:0]      w_c1;
  logic            w_d1;
  logic            w_v1;

  // TLB read side
  logic [IDXW-1:0] r_index;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_pfn0;
  logic [2:0]      r_c0;
  logic            r_d0;
  logic            r_v0;
  logic [19:0]     r_pfn1;
  logic [2:0]      r_c1;
  logic            r_d1;
  logic            r_v1;

  modport slave (
    input  cmd_valid, cmd_op, cmd_vpn2, cmd_asid, cmd_index, cmd_lo0, cmd_lo1,
    output cmd_ready,
    output resp_valid, resp_found, resp_index, resp_vpn2, resp_asid, resp_lo0, resp_lo1,
    input  resp_ready,
    output s_vpn2, s_asid,
    input  s_found, s_index,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );

  modport master (
    output cmd_valid, cmd_op, cmd_vpn2, cmd_asid, cmd_index, cmd_lo0, cmd_lo1,
    input  cmd_ready,
    input  resp_valid, resp_found, resp_index, resp_vpn2, resp_asid, resp_lo0, resp_lo1,
    output resp_ready,
    input  s_vpn2, s_asid,
    output s_found, s_index,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb_ctrl.sv
// Purpose: sequences TLBP/TLBR/TLBWI/TLBWR instructions onto a TLB array's search/read/write ports.
// Latency: accept at edge N, EXEC cycle N..N+1, resp_valid from N+1 edge (cycle N+2) until resp_ready.
// Backpressure: one instruction in flight; cmd_ready only in IDLE, result held until resp_ready.
// Ports: clk, reset (async, active-high); bus (tlb_ctrl_if.slave) carries cmd_*, resp_*,
//        s_* (search), we/w_* (write), r_index/r_* (read).
// Build option: TLB_RANDOM_EN - TLBWR uses a free-running down-counter index instead of cmd_index.
module tlb_ctrl #(
  parameter int TLBNUM = 16
) (
  input logic      clk,
  input logic      reset,
  tlb_ctrl_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [IDXW-1:0] rand_idx;
  logic [IDXW-1:0] wr_idx;

`ifdef TLB_RANDOM_EN
  // Free-running Random register: counts down every non-reset cycle, wraps 0 -> TLBNUM-1.
  logic [IDXW-1:0] rand_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rand_cnt <= IDXW'(TLBNUM - 1);
    end else if (rand_cnt == '0) begin
      rand_cnt <= IDXW'(TLBNUM - 1);
    end else begin
      rand_cnt <= rand_cnt - IDXW'(1);
    end
  end

  assign rand_idx = rand_cnt;
`else
  // No Random register: TLBWR degenerates to TLBWI.
  assign rand_idx = bus.cmd_index;
`endif

  assign wr_idx = (bus.cmd_op == OP_TLBWR) ? rand_idx : bus.cmd_index;

  // All bus outputs are registers owned by this FSM. The per-op operand
  // registers (s_*, r_index, w_*) are loaded only at accept of their own op,
  // so they hold their last value at every other time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= OP_TLBP;
      bus.cmd_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_found <= 1'b0;
      bus.resp_index <= '0;
      bus.resp_vpn2  <= '0;
      bus.resp_asid  <= '0;
      bus.resp_lo0   <= '0;
      bus.resp_lo1   <= '0;
      bus.s_vpn2     <= '0;
      bus.s_asid     <= '0;
      bus.r_index    <= '0;
      bus.we         <= 1'b0;
      bus.w_index    <= '0;
      bus.w_vpn2     <= '0;
      bus.w_asid     <= '0;
      bus.w_g        <= 1'b0;
      bus.w_pfn0     <= '0;
      bus.w_c0       <= '0;
      bus.w_d0       <= 1'b0;
      bus.w_v0       <= 1'b0;
      bus.w_pfn1     <= '0;
      bus.w_c1       <= '0;
      bus.w_d1       <= 1'b0;
      bus.w_v1       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state         <= EXEC;
            bus.cmd_ready <= 1'b0;
            op_q          <= bus.cmd_op;
            case (bus.cmd_op)
              OP_TLBP: begin
                bus.s_vpn2 <= bus.cmd_vpn2;
                bus.s_asid <= bus.cmd_asid;
              end
              OP_TLBR: begin
                bus.r_index <= bus.cmd_index;
              end
              default: begin
                // TLBWI / TLBWR: we rises with EXEC and falls with it.
                bus.we      <= 1'b1;
                bus.w_index <= wr_idx;
                bus.w_vpn2  <= bus.cmd_vpn2;
                bus.w_asid  <= bus.cmd_asid;
                bus.w_g     <= bus.cmd_lo0[0] & bus.cmd_lo1[0];
                bus.w_pfn0  <= bus.cmd_lo0[25:6];
                bus.w_c0    <= bus.cmd_lo0[5:3];
                bus.w_d0    <= bus.cmd_lo0[2];
                bus.w_v0    <= bus.cmd_lo0[1];
                bus.w_pfn1  <= bus.cmd_lo1[25:6];
                bus.w_c1    <= bus.cmd_lo1[5:3];
                bus.w_d1    <= bus.cmd_lo1[2];
                bus.w_v1    <= bus.cmd_lo1[1];
              end
            endcase
          end
        end

        EXEC: begin
          state          <= RESP;
          bus.we         <= 1'b0;
          bus.resp_valid <= 1'b1;
          case (op_q)
            OP_TLBP: begin
              bus.resp_found <= bus.s_found;
              bus.resp_index <= bus.s_found ? bus.s_index : '0;
            end
            OP_TLBR: begin
              bus.resp_found <= 1'b0;
              bus.resp_vpn2  <= bus.r_vpn2;
              bus.resp_asid  <= bus.r_asid;
              // g is a single per-entry bit; report it in both EntryLo images.
              bus.resp_lo0   <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
              bus.resp_lo1   <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
            end
            default: begin
              bus.resp_found <= 1'b0;
            end
          endcase
        end

        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.cmd_ready  <= 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          bus.we         <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.cmd_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
